array_count_compare: RTL and testbench

Sequential, parametrised successor to the single-cycle array count-less step in the fpga test programs. On a `start` pulse it scans one array area of heap memory through a one-cycle-latency read port and counts the elements that satisfy a selectable comparison against a key: less, less-or-equal, equal or greater. The block sits beside the instruction sequencer, which hands it an array number, element count and key, and then waits for `done`. It replaces the combinational loop over `NArea` with a one-element-per-clock pipeline, so the area size scales without widening logic.

---
 rtl/array_count_compare_if.sv | 32 +++
 rtl/array_count_compare.sv | 136 +++++++++++++
 tb/tb_array_count_compare.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/array_count_compare_if.sv
// Sequencer/heap-side bundle for array_count_compare: scan request, result and heap read port.
interface array_count_compare_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 3,
  parameter int NArrays            = 1
);
  localparam int AddressWidth = (NArrays * NArea > 1) ? $clog2(NArrays * NArea) : 1;
  localparam int ArrayWidth   = (NArrays > 1) ? $clog2(NArrays) : 1;

  logic                          start;
  logic [1:0]                    mode;
  logic [ArrayWidth-1:0]         array;
  logic [MemoryElementWidth-1:0] size;
  logic [MemoryElementWidth-1:0] key;
  logic                          heapRead;
  logic [AddressWidth-1:0]       heapAddr;
  logic [MemoryElementWidth-1:0] heapData;
  logic                          busy;
  logic                          done;
  logic [MemoryElementWidth-1:0] count;

  // master: sequencer plus heap memory; slave: the counting block
  modport master (
    output start, mode, array, size, key, heapData,
    input  heapRead, heapAddr, busy, done, count
  );

  modport slave (
    input  start, mode, array, size, key, heapData,
    output heapRead, heapAddr, busy, done, count
  );
endinterface

// File: rtl/array_count_compare.sv
// Counts elements of one heap array area matching less/less-or-equal/equal/greater against a key.
// Latency k+2 cycles (1 when k=0), one element per clock; start is ignored unless idle.
module array_count_compare #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 3,
  parameter int NArrays            = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  array_count_compare_if.slave  bus
);
  localparam int AddressWidth = (NArrays * NArea > 1) ? $clog2(NArrays * NArea) : 1;
  localparam int MW           = MemoryElementWidth;
  localparam logic [MW-1:0] NAreaW = MW'(NArea);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q;
  logic [MW-1:0]           key_q;
  logic [MW-1:0]           k_q;
  logic [MW-1:0]           idx_q;
  logic [MW-1:0]           count_q;
  logic                    read_q, read_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_vld_q;

  logic                    accept;
  logic                    last;
  logic                    hit;
  logic [MW-1:0]           k_in;
  logic [AddressWidth-1:0] base_in;

  assign accept  = (state_q == IDLE) && bus.start;
  assign k_in    = (bus.size < NAreaW) ? bus.size : NAreaW;
  assign base_in = AddressWidth'(bus.array) * AddressWidth'(NArea);
  assign last    = (idx_q == k_q - MW'(1));

  always_comb begin
    hit = 1'b0;
    case (mode_q)
      2'd0:    hit = bus.heapData <  key_q;
      2'd1:    hit = bus.heapData <= key_q;
      2'd2:    hit = bus.heapData == key_q;
      default: hit = bus.heapData >  key_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (k_in != '0) ? SCAN : FINISH;
      SCAN:    if (last) state_d = DRAIN;
      DRAIN:   state_d = FINISH;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, so every port comes straight from a flop.
  always_comb begin
    read_d = 1'b0;
    addr_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          if (k_in != '0) begin
            read_d = 1'b1;
            addr_d = base_in;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (!last) begin
          read_d = 1'b1;
          addr_d = addr_q + AddressWidth'(1);
        end
      end
      DRAIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      key_q    <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_vld_q <= read_q;
      if (accept) begin
        mode_q  <= bus.mode;
        key_q   <= bus.key;
        k_q     <= k_in;
        idx_q   <= '0;
        count_q <= '0;
      end else begin
        if (state_q == SCAN) idx_q <= idx_q + MW'(1);
        // heapData belongs to the read issued in the previous cycle
        if (rd_vld_q && hit) count_q <= count_q + MW'(1);
      end
    end
  end

  assign bus.heapRead = read_q;
  assign bus.heapAddr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_array_count_compare.sv
// Directed scans against a heap model; expected reads and completions are queued and checked by a monitor.
module tb_array_count_compare;
  localparam int MW = 12;
  localparam int NA = 3;
  localparam int NR = 4;

  typedef struct { int addr; int cyc; } rd_exp_t;
  typedef struct { int cnt;  int cyc; } dn_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic [MW-1:0] heap [NA*NR];
  rd_exp_t aq[$];
  dn_exp_t dq[$];

  always #5 clock = ~clock;

  array_count_compare_if #(.MemoryElementWidth(MW), .NArea(NA), .NArrays(NR)) bus ();

  array_count_compare #(.MemoryElementWidth(MW), .NArea(NA), .NArrays(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // One-cycle-latency heap read port
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.heapRead) bus.heapData <= heap[bus.heapAddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every read and every done must match the head of its queue.
  initial begin
    rd_exp_t re;
    dn_exp_t de;
    forever begin
      @(negedge clock);
      #1;
      if (bus.heapRead) begin
        if (aq.size() == 0) begin
          chk("unexpected_read_addr", int'(bus.heapAddr), -1);
        end else begin
          re = aq.pop_front();
          chk("read_addr", int'(bus.heapAddr), re.addr);
          chk("read_cycle", cyc, re.cyc);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done_cycle", cyc, -1);
        end else begin
          de = dq.pop_front();
          chk("done_count", int'(bus.count), de.cnt);
          chk("done_cycle", cyc, de.cyc);
          chk("busy_at_done", int'(bus.busy), 1);
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((aq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    chk("outstanding_after_wait", aq.size() + dq.size(), 0);
  endtask

  task automatic push_scan(input int arr, input int sz, input int s, input int exp);
    int k;
    k = (sz < NA) ? sz : NA;
    for (int i = 0; i < k; i++) aq.push_back('{addr: arr * NA + i, cyc: s + 1 + i});
    dq.push_back('{cnt: exp, cyc: s + ((k == 0) ? 1 : k + 2)});
  endtask

  task automatic run_scan(input int arr, input int sz, input int ky, input int md, input int exp);
    int s;
    @(negedge clock);
    s = cyc;
    bus.array = 2'(arr);
    bus.size  = MW'(sz);
    bus.key   = MW'(ky);
    bus.mode  = 2'(md);
    bus.start = 1'b1;
    push_scan(arr, sz, s, exp);
    @(negedge clock);
    // inputs scrambled after acceptance must not disturb the scan
    bus.start = 1'b0;
    bus.key   = ~MW'(ky);
    bus.mode  = 2'(md) ^ 2'd1;
    bus.array = 2'(arr) ^ 2'd3;
    bus.size  = MW'(1);
    wait_drain(40);
    chk("count_hold", int'(bus.count), exp);
    @(negedge clock);
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.array = '0;
    bus.size  = '0;
    bus.key   = '0;
    for (int i = 0; i < NA * NR; i++) heap[i] = '0;
    heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30;

    repeat (3) @(negedge clock);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_heapRead", int'(bus.heapRead), 0);
    chk("reset_heapAddr", int'(bus.heapAddr), 0);
    chk("reset_count", int'(bus.count), 0);
    reset = 1'b1;

    // 10,20,30 against key 20 in all four modes
    run_scan(0, 3, 20, 0, 1);
    run_scan(0, 3, 20, 1, 2);
    run_scan(0, 3, 20, 2, 1);
    run_scan(0, 3, 20, 3, 1);

    // empty array
    run_scan(0, 0, 7, 1, 0);

    // size above NArea is clamped; heap[3] would count if it were read
    heap[0] = 12'd1; heap[1] = 12'd1; heap[2] = 12'd1; heap[3] = 12'd1;
    run_scan(0, 7, 5, 0, 3);

    // array 2 occupies addresses 6..8
    heap[6] = 12'd5; heap[7] = 12'd5; heap[8] = 12'd9;
    run_scan(2, 3, 5, 2, 2);

    // unsigned extremes and a partial array
    heap[9] = 12'd0; heap[10] = 12'd4095; heap[11] = 12'd100;
    run_scan(3, 2, 0, 3, 1);
    run_scan(3, 3, 4095, 1, 3);

    // reset in cycle 2 of a scan, then a clean rerun
    heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30;
    @(negedge clock);
    s = cyc;
    bus.array = 2'd0; bus.size = 12'd3; bus.key = 12'd20; bus.mode = 2'd1;
    bus.start = 1'b1;
    aq.push_back('{addr: 0, cyc: s + 1});
    aq.push_back('{addr: 1, cyc: s + 2});
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_heapRead", int'(bus.heapRead), 0);
    chk("midrst_heapAddr", int'(bus.heapAddr), 0);
    chk("midrst_count", int'(bus.count), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("midrst_reads_seen", aq.size(), 0);
    run_scan(0, 3, 20, 1, 2);

    // start held high, key changed mid-scan: two back-to-back scans
    heap[3] = 12'd7; heap[4] = 12'd8; heap[5] = 12'd9;
    @(negedge clock);
    s = cyc;
    bus.array = 2'd1; bus.size = 12'd3; bus.key = 12'd9; bus.mode = 2'd0;
    bus.start = 1'b1;
    push_scan(1, 3, s, 2);
    push_scan(1, 3, s + 6, 1);
    repeat (2) @(negedge clock);
    bus.key = 12'd8;
    repeat (5) @(negedge clock);
    bus.start = 1'b0;
    wait_drain(60);
    chk("held_final_count", int'(bus.count), 1);
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
